// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider, multiplier):
// FSM state encoding and default operand widths.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ARITH_DW_N = 8;
  localparam int ARITH_DW_D = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int DW_D = 4
) (
  input  logic [DW_D-1:0] rem_in,
  input  logic            bit_in,
  input  logic [DW_D-1:0] dmag,
  output logic [DW_D-1:0] rem_out,
  output logic            q_bit
);

  // Partial remainder is one bit wider than the divisor so the shift cannot lose data.
  logic [DW_D:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, dmag});
  // The kept remainder is always below dmag, so it fits DW_D bits.
  assign rem_out = q_bit ? DW_D'(shifted - {1'b0, dmag}) : shifted[DW_D-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Signed sequential restoring divider: magnitudes are divided MSB first, then
// signs are applied and the quotient range-checked in a final fix-up cycle.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int DW_N = ARITH_DW_N,
  parameter int DW_D = ARITH_DW_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DW_N-1:0]         dividend,
  input  logic [DW_D-1:0]         divisor,
  input  logic                    start,
  output logic [DW_D-1:0]         quotient,
  output logic [DW_D-1:0]         remainder,
  output logic [$clog2(DW_N)-1:0] count,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int CW = $clog2(DW_N);
  localparam logic [DW_N-1:0] Q_POS_MAX = DW_N'((1 << (DW_D - 1)) - 1);
  localparam logic [DW_N-1:0] Q_NEG_MAG = DW_N'(1 << (DW_D - 1));

  state_t          state;
  // Dividend magnitude shifts out MSB first while quotient bits shift in at the LSB.
  logic [DW_N-1:0] dvd_reg;
  logic [DW_D-1:0] dsr_mag;
  logic [DW_D-1:0] rem_reg;
  logic            dvd_neg;
  logic            dsr_neg;

  logic [DW_N-1:0] dvd_abs;
  logic [DW_D-1:0] dsr_abs;
  logic [DW_D-1:0] rem_next;
  logic            q_bit;
  logic            q_neg;
  logic            fix_ovf;
  logic [DW_D-1:0] q_fix;
  logic [DW_D-1:0] r_fix;

  assign dvd_abs = dividend[DW_N-1] ? -dividend : dividend;
  assign dsr_abs = divisor[DW_D-1] ? -divisor : divisor;

  div_step #(.DW_D(DW_D)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_reg[DW_N-1]),
    .dmag    (dsr_mag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Negative results may reach magnitude 2^(DW_D-1); positive ones stop one short.
  assign q_neg   = dvd_neg ^ dsr_neg;
  assign fix_ovf = q_neg ? (dvd_reg > Q_NEG_MAG) : (dvd_reg > Q_POS_MAX);
  assign q_fix   = q_neg ? -dvd_reg[DW_D-1:0] : dvd_reg[DW_D-1:0];
  assign r_fix   = dvd_neg ? -rem_reg : rem_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dvd_reg     <= '0;
      dsr_mag     <= '0;
      rem_reg     <= '0;
      dvd_neg     <= 1'b0;
      dsr_neg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              dvd_reg     <= dvd_abs;
              dsr_mag     <= dsr_abs;
              dvd_neg     <= dividend[DW_N-1];
              dsr_neg     <= divisor[DW_D-1];
              rem_reg     <= '0;
              count       <= '0;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          dvd_reg <= {dvd_reg[DW_N-2:0], q_bit};
          rem_reg <= rem_next;
          count   <= count + 1'b1;
          if (count == CW'(DW_N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          overflow  <= fix_ovf;
          quotient  <= fix_ovf ? '0 : q_fix;
          remainder <= fix_ovf ? '0 : r_fix;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider: signed results, latency,
// divide-by-zero, overflow and asynchronous reset mid-operation.
module tb_restoring_divider;

  logic       clk;
  logic       reset;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       start;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  restoring_divider dut (
    .clk         (clk),
    .reset       (reset),
    .dividend    (dividend),
    .divisor     (divisor),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".quotient"}, 32'(quotient), 0);
    check({tag, ".remainder"}, 32'(remainder), 0);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".dbz"}, 32'(div_by_zero), 0);
    check({tag, ".ovf"}, 32'(overflow), 0);
  endtask

  // Full normal-path transaction; operands are scrambled while RUN/FIX to prove they are ignored.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic eovf);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    check("accept.busy", 32'(busy), 1);
    check("accept.count", 32'(count), 0);
    check("accept.ovf", 32'(overflow), 0);
    check("accept.dbz", 32'(div_by_zero), 0);
    for (int k = 1; k <= 8; k++) begin
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      @(posedge clk); #1;
      check("run.count", 32'(count), 32'(k % 8));
    end
    lat = 8;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 9);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("overflow", 32'(overflow), 32'(eovf));
    check("done.busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("hold.done", 32'(done), 1);
    check("hold.quotient", 32'(quotient), 32'(eq));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("release.done", 32'(done), 0);
    check("persist.quotient", 32'(quotient), 32'(eq));
    $display("div %0d / %0d -> q=%0d r=%0d ovf=%0b lat=%0d",
             $signed(a), $signed(b), $signed(quotient), $signed(remainder), overflow, lat);
  endtask

  initial begin
    int waited;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    do_div(8'd20,          4'd5,          4'd4,    4'd0,    1'b0);
    do_div(-8'sd14,        4'd7,          4'b1110, 4'd0,    1'b0);
    do_div(8'd16,          -4'sd4,        4'b1100, 4'd0,    1'b0);
    do_div(-8'sd7,         4'd2,          4'b1101, 4'b1111, 1'b0);
    do_div(8'd7,           -4'sd2,        4'b1101, 4'd1,    1'b0);
    do_div(8'd100,         4'd3,          4'd0,    4'd0,    1'b1);
    do_div(8'd0,           4'd3,          4'd0,    4'd0,    1'b0);
    do_div(8'd64,          4'b1000,       4'b1000, 4'd0,    1'b0);
    do_div(8'd8,           4'd1,          4'd0,    4'd0,    1'b1);
    do_div(-8'sd8,         4'd1,          4'b1000, 4'd0,    1'b0);
    do_div(8'b1000_0000,   4'b1000,       4'd0,    4'd0,    1'b1);

    // Divide by zero completes on the accept edge without ever going busy.
    @(negedge clk);
    dividend = 8'd5;
    divisor  = 4'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    check("dbz.flag", 32'(div_by_zero), 1);
    check("dbz.done", 32'(done), 1);
    check("dbz.busy", 32'(busy), 0);
    check("dbz.quotient", 32'(quotient), 0);
    check("dbz.remainder", 32'(remainder), 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("dbz.release.done", 32'(done), 0);
    check("dbz.release.busy", 32'(busy), 0);
    $display("div 5 / 0 -> dbz=%0b q=%0d", div_by_zero, $signed(quotient));

    do_div(-8'sd5,         -4'sd3,        4'd1,    4'b1110, 1'b0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    dividend = 8'd20;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    waited = 0;
    while (count != 3'd4 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("midrun.count", 32'(count), 4);
    start = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("midrun.reset");
    $display("reset at count=4 -> q=%0d busy=%0b done=%0b", $signed(quotient), busy, done);
    @(negedge clk);
    reset = 1'b1;
    do_div(8'd20, 4'd5, 4'd4, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
